// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch stage for the prco core.
// Holds the PC, issues one request per fetch enable to local memory,
// latches the returned word and hands it to decode as a one-cycle pulse.
// Branch redirects, decode stalls and memory timeouts are handled here.
module prco_fetch #(
  parameter logic [15:0] P_RESET_PC = 16'h0000,
  parameter int          P_TIMEOUT  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce_fetch,
  input  logic        i_stall,
  input  logic        i_branch_en,
  input  logic [15:0] i_branch_addr,
  output logic        q_mem_ce_fetch,
  output logic [15:0] q_mem_addr,
  input  logic        i_mem_ce_dec,
  input  logic [15:0] i_mem_douta,
  output logic [15:0] q_instr,
  output logic [15:0] q_instr_pc,
  output logic        q_ce_dec,
  output logic [15:0] q_pc,
  output logic        q_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        busy_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] instr_nxt;
  logic [15:0] instr_pc_nxt;
  logic [15:0] mem_addr_nxt;
  logic        mem_ce_nxt;
  logic        ce_dec_nxt;
  logic        discard, discard_nxt;
  logic [3:0]  count, count_nxt;

  // State and output registers; every output is driven straight from a flop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      q_busy         <= 1'b0;
      q_pc           <= P_RESET_PC;
      q_instr        <= 16'h0000;
      q_instr_pc     <= 16'h0000;
      q_mem_addr     <= 16'h0000;
      q_mem_ce_fetch <= 1'b0;
      q_ce_dec       <= 1'b0;
      discard        <= 1'b0;
      count          <= 4'd0;
    end else begin
      state          <= state_nxt;
      q_busy         <= busy_nxt;
      q_pc           <= pc_nxt;
      q_instr        <= instr_nxt;
      q_instr_pc     <= instr_pc_nxt;
      q_mem_addr     <= mem_addr_nxt;
      q_mem_ce_fetch <= mem_ce_nxt;
      q_ce_dec       <= ce_dec_nxt;
      discard        <= discard_nxt;
      count          <= count_nxt;
    end
  end

  // Next-state and next-output logic; a branch overrides the PC last so it wins.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = q_pc;
    instr_nxt    = q_instr;
    instr_pc_nxt = q_instr_pc;
    mem_addr_nxt = q_mem_addr;
    mem_ce_nxt   = 1'b0;
    ce_dec_nxt   = 1'b0;
    discard_nxt  = discard;
    count_nxt    = count;

    case (state)
      S_IDLE: begin
        if (!i_branch_en && i_ce_fetch) begin
          state_nxt    = S_REQ;
          mem_addr_nxt = q_pc;
          mem_ce_nxt   = 1'b1;
        end
      end

      S_REQ: begin
        count_nxt = 4'd0;
        state_nxt = S_WAIT;
        if (i_branch_en) begin
          discard_nxt = 1'b1;
        end
      end

      S_WAIT: begin
        count_nxt = count + 4'd1;
        if (i_mem_ce_dec) begin
          if (i_branch_en) begin
            // Response collides with a redirect: drop it and go fetch the target.
            state_nxt    = S_REQ;
            mem_addr_nxt = i_branch_addr;
            mem_ce_nxt   = 1'b1;
            discard_nxt  = 1'b0;
          end else if (discard) begin
            state_nxt    = S_REQ;
            mem_addr_nxt = q_pc;
            mem_ce_nxt   = 1'b1;
            discard_nxt  = 1'b0;
          end else begin
            instr_nxt    = i_mem_douta;
            instr_pc_nxt = q_mem_addr;
            pc_nxt       = q_mem_addr + 16'd1;
            if (i_stall) begin
              state_nxt = S_HOLD;
            end else begin
              ce_dec_nxt = 1'b1;
              state_nxt  = S_IDLE;
            end
          end
        end else begin
          if (i_branch_en) begin
            discard_nxt = 1'b1;
          end
          // No answer within the window: re-issue the same address.
          if (count_nxt == 4'(P_TIMEOUT)) begin
            state_nxt  = S_REQ;
            mem_ce_nxt = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (i_branch_en) begin
          state_nxt = S_IDLE;
        end else if (!i_stall) begin
          ce_dec_nxt = 1'b1;
          state_nxt  = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (i_branch_en) begin
      pc_nxt = i_branch_addr;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch: directed bench for the prco fetch stage.
module tb_prco_fetch;

  logic        clk;
  logic        reset;
  logic        ce_fetch;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_addr;
  logic        mem_ce_fetch;
  logic [15:0] mem_addr;
  logic        mem_ce_dec;
  logic [15:0] mem_douta;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        ce_dec;
  logic [15:0] pc;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;

  prco_fetch #(
    .P_RESET_PC(16'h0000),
    .P_TIMEOUT (4)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_ce_fetch    (ce_fetch),
    .i_stall       (stall),
    .i_branch_en   (branch_en),
    .i_branch_addr (branch_addr),
    .q_mem_ce_fetch(mem_ce_fetch),
    .q_mem_addr    (mem_addr),
    .i_mem_ce_dec  (mem_ce_dec),
    .i_mem_douta   (mem_douta),
    .q_instr       (instr),
    .q_instr_pc    (instr_pc),
    .q_ce_dec      (ce_dec),
    .q_pc          (pc),
    .q_busy        (busy)
  );

  // 10 ns core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ceF, input logic st, input logic brEn,
                               input logic [15:0] brAddr, input logic memDec,
                               input logic [15:0] memData);
    ce_fetch    = ceF;
    stall       = st;
    branch_en   = brEn;
    branch_addr = brAddr;
    mem_ce_dec  = memDec;
    mem_douta   = memData;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One unstalled fetch with a prompt memory answer.
  task automatic doFetch(input logic [15:0] data, input logic [15:0] addr, input logic [15:0] nextPc);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("req_ce", 16'(mem_ce_fetch), 16'd1);
    checkOutput("req_addr", mem_addr, addr);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("req_ce_drop", 16'(mem_ce_fetch), 16'd0);
    checkOutput("no_early_dec", 16'(ce_dec), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, data);
    step();
    checkOutput("dec_pulse", 16'(ce_dec), 16'd1);
    checkOutput("instr", instr, data);
    checkOutput("instr_pc", instr_pc, addr);
    checkOutput("pc_next", pc, nextPc);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("dec_single", 16'(ce_dec), 16'd0);
    checkOutput("idle_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    step();
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_ce", 16'(mem_ce_fetch), 16'd0);
    checkOutput("rst_dec", 16'(ce_dec), 16'd0);
    checkOutput("rst_instr", instr, 16'h0000);
    reset = 1'b0;
    step();

    // First fetch, then three more back to back; the second one is stalled.
    doFetch(16'h24ab, 16'h0000, 16'h0001);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("st_req_addr", mem_addr, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h23cd);
    step();
    checkOutput("st_no_dec", 16'(ce_dec), 16'd0);
    checkOutput("st_instr", instr, 16'h23cd);
    checkOutput("st_busy", 16'(busy), 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("st_hold_dec", 16'(ce_dec), 16'd0);
      checkOutput("st_hold_instr", instr, 16'h23cd);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("st_release_dec", 16'(ce_dec), 16'd1);
    checkOutput("st_instr_pc", instr_pc, 16'h0001);
    checkOutput("st_pc", pc, 16'h0002);
    step();
    checkOutput("st_dec_single", 16'(ce_dec), 16'd0);

    doFetch(16'h1460, 16'h0002, 16'h0003);
    doFetch(16'h1461, 16'h0003, 16'h0004);

    // Branch during WAIT: stale word is dropped and the target is fetched.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("br_req_addr", mem_addr, 16'h0004);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00aa, 1'b0, 16'h0);
    step();
    checkOutput("br_pc", pc, 16'h00aa);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1460);
    step();
    checkOutput("br_stale_dec", 16'(ce_dec), 16'd0);
    checkOutput("br_reissue_ce", 16'(mem_ce_fetch), 16'd1);
    checkOutput("br_reissue_addr", mem_addr, 16'h00aa);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("br_wait_dec", 16'(ce_dec), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h00ca);
    step();
    checkOutput("br_dec", 16'(ce_dec), 16'd1);
    checkOutput("br_instr", instr, 16'h00ca);
    checkOutput("br_instr_pc", instr_pc, 16'h00aa);
    checkOutput("br_pc_next", pc, 16'h00ab);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();

    // Memory silent for four WAIT cycles: request re-issued at same address.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    checkOutput("to_req_addr", mem_addr, 16'h00ab);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("to_wait_ce", 16'(mem_ce_fetch), 16'd0);
    end
    step();
    checkOutput("to_reissue_ce", 16'(mem_ce_fetch), 16'd1);
    checkOutput("to_reissue_addr", mem_addr, 16'h00ab);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
    step();
    checkOutput("to_dec", 16'(ce_dec), 16'd1);
    checkOutput("to_instr", instr, 16'h5555);
    checkOutput("to_pc", pc, 16'h00ac);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h6666);
    step();
    checkOutput("to_once", 16'(ce_dec), 16'd0);
    checkOutput("idle_ignore_instr", instr, 16'h5555);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();

    // Branch in IDLE to the top word, then fetch it and wrap the PC.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hffff, 1'b0, 16'h0);
    step();
    checkOutput("wrap_br_pc", pc, 16'hffff);
    checkOutput("wrap_br_busy", 16'(busy), 16'd0);
    doFetch(16'h1234, 16'hffff, 16'h0000);

    // Asynchronous reset in the middle of WAIT, then a late response.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_busy", 16'(busy), 16'd0);
    checkOutput("arst_pc", pc, 16'h0000);
    checkOutput("arst_addr", mem_addr, 16'h0000);
    checkOutput("arst_instr", instr, 16'h0000);
    checkOutput("arst_instr_pc", instr_pc, 16'h0000);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hbeef);
    step();
    checkOutput("late_dec", 16'(ce_dec), 16'd0);
    checkOutput("late_instr", instr, 16'h0000);
    checkOutput("late_busy", 16'(busy), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
